// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package regfile_wb_pkg;

    localparam int WB_ADDR_NBITS   = 5;
    localparam int WB_DATA_NBITS   = 32;
    localparam int WB_QUEUE_DEPTH  = 2;
    localparam int WB_STARVE_NBITS = 4;

    typedef struct packed {
        logic [WB_ADDR_NBITS-1:0] addr;
        logic [WB_DATA_NBITS-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Producer / register-file bus of the writeback arbiter.
// Forwarding outputs exist only when REGFILE_WB_ARB_FWD_EN is defined.
interface regfile_wb_arbiter_if #(
    parameter int p_addr_nbits = 5,
    parameter int p_data_nbits = 32
);
    logic                    alu_val;
    logic                    alu_rdy;
    logic [p_addr_nbits-1:0] alu_waddr;
    logic [p_data_nbits-1:0] alu_wdata;
    logic                    lng_val;
    logic                    lng_rdy;
    logic [p_addr_nbits-1:0] lng_waddr;
    logic [p_data_nbits-1:0] lng_wdata;
    logic                    wr_en;
    logic [p_addr_nbits-1:0] wr_addr;
    logic [p_data_nbits-1:0] wr_data;
`ifdef REGFILE_WB_ARB_FWD_EN
    logic                    fwd_val;
    logic [p_addr_nbits-1:0] fwd_addr;
    logic [p_data_nbits-1:0] fwd_data;

    modport master (
        output alu_val, alu_waddr, alu_wdata, lng_val, lng_waddr, lng_wdata,
        input  alu_rdy, lng_rdy, wr_en, wr_addr, wr_data, fwd_val, fwd_addr, fwd_data
    );
    modport slave (
        input  alu_val, alu_waddr, alu_wdata, lng_val, lng_waddr, lng_wdata,
        output alu_rdy, lng_rdy, wr_en, wr_addr, wr_data, fwd_val, fwd_addr, fwd_data
    );
`else
    modport master (
        output alu_val, alu_waddr, alu_wdata, lng_val, lng_waddr, lng_wdata,
        input  alu_rdy, lng_rdy, wr_en, wr_addr, wr_data
    );
    modport slave (
        input  alu_val, alu_waddr, alu_wdata, lng_val, lng_waddr, lng_wdata,
        output alu_rdy, lng_rdy, wr_en, wr_addr, wr_data
    );
`endif
endinterface

// File: rtl/regfile_wb_queue.sv
// Small FIFO holding long-latency writeback requests; storage is not reset.
module regfile_wb_queue
    import regfile_wb_pkg::*;
#(
    parameter type T = wb_req_t
)(
    input  logic clk,
    input  logic reset,
    input  logic enq_i,
    input  T     enq_data_i,
    input  logic deq_i,
    output T     head_o,
    output logic full_o,
    output logic empty_o
);
    localparam int PTR_NBITS = $clog2(WB_QUEUE_DEPTH);
    localparam int CNT_NBITS = $clog2(WB_QUEUE_DEPTH + 1);

    T                     mem_q [WB_QUEUE_DEPTH];
    logic [PTR_NBITS-1:0] head_q, tail_q;
    logic [CNT_NBITS-1:0] count_q;
    logic                 enq_ok, deq_ok;

    assign full_o  = (count_q == CNT_NBITS'(WB_QUEUE_DEPTH));
    assign empty_o = (count_q == '0);
    assign enq_ok  = enq_i && !full_o;
    assign deq_ok  = deq_i && !empty_o;
    assign head_o  = mem_q[head_q];

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (enq_ok) tail_q <= tail_q + PTR_NBITS'(1);
            if (deq_ok) head_q <= head_q + PTR_NBITS'(1);
            if (enq_ok && !deq_ok)      count_q <= count_q + CNT_NBITS'(1);
            else if (deq_ok && !enq_ok) count_q <= count_q - CNT_NBITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (enq_ok) mem_q[tail_q] <= enq_data_i;
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: ALU path wins, long path is queued and protected by a
// starvation counter. REGFILE_WB_ARB_FWD_EN adds combinational bypass outputs.
module regfile_wb_arbiter
    import regfile_wb_pkg::*;
#(
    parameter int p_data_nbits   = WB_DATA_NBITS,
    parameter int p_addr_nbits   = WB_ADDR_NBITS,
    parameter int p_starve_limit = 4
)(
    input logic                 clk,
    input logic                 reset,
    regfile_wb_arbiter_if.slave bus
);
    typedef struct packed {
        logic [p_addr_nbits-1:0] addr;
        logic [p_data_nbits-1:0] data;
    } req_t;

    localparam logic [WB_STARVE_NBITS-1:0] STARVE_LAST = WB_STARVE_NBITS'(p_starve_limit - 1);

    req_t alu_req, lng_req, head, gnt_req;
    logic q_full, q_empty;
    logic alu_gnt, q_gnt, gnt;

    logic                       force_q, force_d;
    logic [WB_STARVE_NBITS-1:0] starve_q, starve_d;
    logic                       wr_en_q, wr_en_d;
    logic [p_addr_nbits-1:0]    wr_addr_q, wr_addr_d;
    logic [p_data_nbits-1:0]    wr_data_q, wr_data_d;

    assign alu_req = '{addr: bus.alu_waddr, data: bus.alu_wdata};
    assign lng_req = '{addr: bus.lng_waddr, data: bus.lng_wdata};

    regfile_wb_queue #(.T(req_t)) u_queue (
        .clk        (clk),
        .reset      (reset),
        .enq_i      (bus.lng_val),
        .enq_data_i (lng_req),
        .deq_i      (q_gnt),
        .head_o     (head),
        .full_o     (q_full),
        .empty_o    (q_empty)
    );

    // Ready signals depend on registered state only.
    assign bus.alu_rdy = !force_q;
    assign bus.lng_rdy = !q_full;

    always_comb begin
        alu_gnt   = bus.alu_val && !force_q;
        q_gnt     = !alu_gnt && !q_empty;
        gnt       = alu_gnt || q_gnt;
        gnt_req   = alu_gnt ? alu_req : head;
        wr_en_d   = gnt && (gnt_req.addr != '0);
        wr_addr_d = gnt ? gnt_req.addr : wr_addr_q;
        wr_data_d = gnt ? gnt_req.data : wr_data_q;
        starve_d  = starve_q;
        force_d   = force_q;
        if (q_gnt || q_empty) begin
            starve_d = '0;
            force_d  = 1'b0;
        end else if (alu_gnt) begin
            starve_d = starve_q + WB_STARVE_NBITS'(1);
            if (starve_q == STARVE_LAST) force_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            force_q   <= 1'b0;
            starve_q  <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            force_q   <= force_d;
            starve_q  <= starve_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;

`ifdef REGFILE_WB_ARB_FWD_EN
    // Bypass copy of this cycle's grant, forced quiet while reset is held.
    assign bus.fwd_val  = reset && wr_en_d;
    assign bus.fwd_addr = reset ? gnt_req.addr : '0;
    assign bus.fwd_data = reset ? gnt_req.data : '0;
`endif

endmodule
